// File: rtl/key_uart_queue.sv
// PS/2 key-release capture and manual byte entry feeding a FIFO that drains into a UART transmitter.
// Optional macro KEY_UART_QUEUE_EXT_KEY_EN enables 0xE0-prefixed extended key pairs.
module key_uart_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int TICK_W = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        scancode,
  input  logic                     new_code,
  input  logic [DATA_W-1:0]        sw_data,
  input  logic                     send_pulse,
  input  logic                     clr_ovf,
  input  logic                     tx_busy,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        last_key,
  output logic                     key_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     disp_tick
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [DATA_W-1:0] CODE_F0 = DATA_W'(8'hF0);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, ACK = 2'd2, DRAIN = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]       count_q, count_d;
  logic                armed_q, armed_d;
  logic                pend_q, pend_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;
  logic                ovf_q, ovf_d;
  logic                tx_start_q, tx_start_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [DATA_W-1:0]   last_key_q, last_key_d;
  logic                key_valid_q, key_valid_d;
  logic                disp_tick_q, disp_tick_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [3:0]          ack_cnt_q, ack_cnt_d;
  logic                pop_s, key_ev_s, drop_s;
  logic [1:0]          push_n_s;
  logic [CW:0]         free_s, key_need_s;
`ifdef KEY_UART_QUEUE_EXT_KEY_EN
  localparam logic [DATA_W-1:0] CODE_E0 = DATA_W'(8'hE0);
  logic                ext_q, ext_d;
  logic [AW-1:0]       wr1_s;
`endif

  // Next-state logic for capture, queue, drain FSM and tick divider.
  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    armed_d     = armed_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    tx_data_d   = tx_data_q;
    last_key_d  = last_key_q;
    key_valid_d = 1'b0;
    tx_start_d  = 1'b0;
    ack_cnt_d   = ack_cnt_q;
    push_n_s    = 2'd0;
    drop_s      = 1'b0;

    pop_s    = (state_q == IDLE) && (count_q != '0) && !tx_busy;
    key_ev_s = new_code && armed_q && (scancode != CODE_F0);
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    free_s   = (CW+1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, pop_s};

    if (new_code) begin
      if (scancode == CODE_F0) armed_d = 1'b1;
      else if (armed_q)        armed_d = 1'b0;
      else                     armed_d = armed_q;
    end else begin
      armed_d = armed_q;
    end

`ifdef KEY_UART_QUEUE_EXT_KEY_EN
    ext_d = ext_q;
    wr1_s = wr_q + AW'(1);
    if (new_code && !armed_q && (scancode == CODE_E0)) ext_d = 1'b1;
    else if (key_ev_s)                                  ext_d = 1'b0;
    else                                                ext_d = ext_q;
    key_need_s = ext_q ? (CW+1)'(2) : (CW+1)'(1);
`else
    key_need_s = (CW+1)'(1);
`endif

    if (key_ev_s) begin
      last_key_d  = scancode;
      key_valid_d = 1'b1;
      if (free_s >= key_need_s) begin
`ifdef KEY_UART_QUEUE_EXT_KEY_EN
        if (ext_q) begin
          mem_d[wr_q]  = CODE_E0;
          mem_d[wr1_s] = scancode;
          push_n_s     = 2'd2;
        end else begin
          mem_d[wr_q] = scancode;
          push_n_s    = 2'd1;
        end
`else
        mem_d[wr_q] = scancode;
        push_n_s    = 2'd1;
`endif
      end else begin
        drop_s = 1'b1;
      end
    end else if (pend_q) begin
      pend_d = 1'b0;
      if (free_s >= (CW+1)'(1)) begin
        mem_d[wr_q] = pend_data_q;
        push_n_s    = 2'd1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      pend_d = pend_q;
    end

    // A new request overrides whatever the pending slot held.
    if (send_pulse) begin
      pend_d      = 1'b1;
      pend_data_d = sw_data;
    end else begin
      pend_data_d = pend_data_q;
    end

    wr_d    = wr_q + AW'(push_n_s);
    rd_d    = rd_q + AW'(pop_s);
    count_d = count_q + CW'(push_n_s) - CW'(pop_s);
    ovf_d   = (ovf_q && !clr_ovf) || drop_s;

    case (state_q)
      IDLE: begin
        if (pop_s) begin
          state_d    = SEND;
          tx_start_d = 1'b1;
          tx_data_d  = mem_q[rd_q];
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        state_d   = ACK;
        ack_cnt_d = 4'd0;
      end
      ACK: begin
        if (tx_busy)                  state_d = DRAIN;
        else if (ack_cnt_q == 4'd15)  state_d = IDLE;
        else                          ack_cnt_d = ack_cnt_q + 4'd1;
      end
      DRAIN: begin
        if (!tx_busy) state_d = IDLE;
        else          state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase

    tick_d      = tick_q + TICK_W'(1);
    disp_tick_d = &tick_q;
  end

  // Queue storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      armed_q     <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      ovf_q       <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      last_key_q  <= '0;
      key_valid_q <= 1'b0;
      disp_tick_q <= 1'b0;
      tick_q      <= '0;
      ack_cnt_q   <= 4'd0;
`ifdef KEY_UART_QUEUE_EXT_KEY_EN
      ext_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      armed_q     <= armed_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      ovf_q       <= ovf_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      last_key_q  <= last_key_d;
      key_valid_q <= key_valid_d;
      disp_tick_q <= disp_tick_d;
      tick_q      <= tick_d;
      ack_cnt_q   <= ack_cnt_d;
`ifdef KEY_UART_QUEUE_EXT_KEY_EN
      ext_q       <= ext_d;
`endif
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign last_key  = last_key_q;
  assign key_valid = key_valid_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign ovf       = ovf_q;
  assign disp_tick = disp_tick_q;
endmodule

// File: tb/tb_key_uart_queue.sv
// Directed bench for key_uart_queue: per-cycle vector table plus multi-cycle drain, timeout, extended-key and reset sequences.
module tb_key_uart_queue;
  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] scancode = '0;
  logic          new_code = 1'b0;
  logic [DW-1:0] sw_data = '0;
  logic          send_pulse = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          tx_busy = 1'b1;
  logic [DW-1:0] tx_data;
  logic          tx_start;
  logic [DW-1:0] last_key;
  logic          key_valid;
  logic [3:0]    count;
  logic          empty, full, ovf, disp_tick;

  key_uart_queue #(.DATA_W(DW), .DEPTH(DEPTH), .TICK_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .scancode(scancode), .new_code(new_code),
    .sw_data(sw_data), .send_pulse(send_pulse), .clr_ovf(clr_ovf), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_start(tx_start), .last_key(last_key), .key_valid(key_valid),
    .count(count), .empty(empty), .full(full), .ovf(ovf), .disp_tick(disp_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          nc;
    logic [DW-1:0] sc;
    logic          sp;
    logic [DW-1:0] sw;
    logic          co;
    int            cnt;
    logic          ov;
    logic          kv;
    logic [DW-1:0] lk;
  } vec_t;

  vec_t          tbl [26];
  int            vectors = 0;
  int            errors = 0;
  int            mode = 0;      // 0: busy held high, 1: responder, 2: busy tied low
  int            busy_len = 3;
  int            busy_cnt = 0;
  int            cyc = 0;
  int            kv_seen = 0;
  logic [DW-1:0] tx_q [$];
  int            txc_q [$];
  logic [DW-1:0] exp_drain [8];
  int            first_tick;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample after the edge, log strobes, update the UART busy model.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (key_valid) kv_seen++;
    if (tx_start) begin
      tx_q.push_back(tx_data);
      txc_q.push_back(cyc);
    end
    if (mode == 1) begin
      if (tx_start) busy_cnt = busy_len;
      tx_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
    end else begin
      tx_busy = (mode == 0);
    end
  endtask

  task automatic step(input logic nc, input logic [DW-1:0] sc, input logic sp,
                      input logic [DW-1:0] sw, input logic co);
    new_code = nc; scancode = sc; send_pulse = sp; sw_data = sw; clr_ovf = co;
    tick();
    new_code = 1'b0; send_pulse = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic key(input logic [DW-1:0] sc);
    step(1'b1, sc, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'h1C, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 8'h1C, 1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b1, 8'h1C};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 8'h1C};
    tbl[4]  = '{1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 8'h1C};
    tbl[5]  = '{1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 8'h1C};
    tbl[6]  = '{1'b1, 8'h32, 1'b1, 8'hA5, 1'b0, 2, 1'b0, 1'b1, 8'h32};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3, 1'b0, 1'b0, 8'h32};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 3, 1'b0, 1'b0, 8'h32};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 4, 1'b0, 1'b0, 8'h32};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 5, 1'b0, 1'b0, 8'h32};
    tbl[11] = '{1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 5, 1'b0, 1'b0, 8'h32};
    tbl[12] = '{1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 6, 1'b0, 1'b1, 8'h01};
    tbl[13] = '{1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 6, 1'b0, 1'b0, 8'h01};
    tbl[14] = '{1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 7, 1'b0, 1'b1, 8'h02};
    tbl[15] = '{1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 7, 1'b0, 1'b0, 8'h02};
    tbl[16] = '{1'b1, 8'h03, 1'b0, 8'h00, 1'b0, 8, 1'b0, 1'b1, 8'h03};
    tbl[17] = '{1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 8, 1'b0, 1'b0, 8'h03};
    tbl[18] = '{1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 8, 1'b1, 1'b1, 8'h04};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8, 1'b0, 1'b0, 8'h04};
    tbl[20] = '{1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 8, 1'b0, 1'b0, 8'h04};
    tbl[21] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8, 1'b1, 1'b0, 8'h04};
    tbl[22] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8, 1'b0, 1'b0, 8'h04};
    tbl[23] = '{1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 8, 1'b0, 1'b0, 8'h04};
    tbl[24] = '{1'b1, 8'h05, 1'b0, 8'h00, 1'b1, 8, 1'b1, 1'b1, 8'h05};
    tbl[25] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8, 1'b0, 1'b0, 8'h05};
    exp_drain = '{8'h1C, 8'h32, 8'hA5, 8'h11, 8'h22, 8'h01, 8'h02, 8'h03};

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_last_key", last_key, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", ovf, 0);
    check("rst_disp_tick", disp_tick, 0);
    rst_n = 1'b1;

    // Display tick: first pulse 2^TW cycles after reset, one cycle wide
    first_tick = -1;
    for (int i = 1; i <= 40 && first_tick < 0; i++) begin
      tick();
      if (disp_tick) first_tick = i;
    end
    check("disp_tick_period", first_tick, 16);
    tick();
    check("disp_tick_width", disp_tick, 0);

    // Table phase with the transmitter held busy so nothing drains
    mode = 0;
    for (int i = 0; i < 26; i++) begin
      step(tbl[i].nc, tbl[i].sc, tbl[i].sp, tbl[i].sw, tbl[i].co);
      check($sformatf("v%0d_count", i), count, tbl[i].cnt);
      check($sformatf("v%0d_ovf", i), ovf, tbl[i].ov);
      check($sformatf("v%0d_key_valid", i), key_valid, tbl[i].kv);
      check($sformatf("v%0d_last_key", i), last_key, tbl[i].lk);
      check($sformatf("v%0d_empty", i), empty, (tbl[i].cnt == 0) ? 1 : 0);
      check($sformatf("v%0d_full", i), full, (tbl[i].cnt == DEPTH) ? 1 : 0);
      check($sformatf("v%0d_tx_start", i), tx_start, 0);
    end

    // Drain through a responding UART: strict FIFO order and spacing
    tx_q.delete(); txc_q.delete();
    mode = 1; busy_len = 3;
    for (int i = 0; i < 300 && tx_q.size() < 8; i++) tick();
    check("drain_bytes", tx_q.size(), 8);
    for (int i = 0; i < tx_q.size() && i < 8; i++) begin
      check($sformatf("drain_byte%0d", i), tx_q[i], exp_drain[i]);
      if (i > 0) check($sformatf("drain_gap%0d", i), (txc_q[i] - txc_q[i-1]) >= 4 ? 1 : 0, 1);
    end
    for (int i = 0; i < 10; i++) tick();
    check("drain_count", count, 0);
    check("drain_empty", empty, 1);

    // Release detect and ACK timeout with tx_busy tied low
    mode = 2;
    tick();
    tx_q.delete(); txc_q.delete(); kv_seen = 0;
    key(8'h1C); key(8'hF0); key(8'h1C);
    check("rel_key_valid_once", kv_seen, 1);
    check("rel_last_key", last_key, 8'h1C);
    key(8'hF0); key(8'h33);
    for (int i = 0; i < 60; i++) tick();
    check("to_tx_count", tx_q.size(), 2);
    if (tx_q.size() == 2) begin
      check("to_tx0", tx_q[0], 8'h1C);
      check("to_tx1", tx_q[1], 8'h33);
      check("to_gap", txc_q[1] - txc_q[0], 18);
    end

    // Extended key prefix
    tx_q.delete(); txc_q.delete();
    key(8'hE0); key(8'hF0); key(8'h75);
    for (int i = 0; i < 60; i++) tick();
`ifdef KEY_UART_QUEUE_EXT_KEY_EN
    check("ext_tx_count", tx_q.size(), 2);
    if (tx_q.size() == 2) begin
      check("ext_tx0", tx_q[0], 8'hE0);
      check("ext_tx1", tx_q[1], 8'h75);
    end
`else
    check("ext_tx_count", tx_q.size(), 1);
    if (tx_q.size() == 1) check("ext_tx0", tx_q[0], 8'h75);
`endif
    check("ext_last_key", last_key, 8'h75);

    // Reset while draining with three bytes still queued
    mode = 0;
    tick();
    key(8'hF0); key(8'h41); key(8'hF0); key(8'h42);
    key(8'hF0); key(8'h43); key(8'hF0); key(8'h44);
    check("mid_fill_count", count, 4);
    tx_q.delete(); txc_q.delete();
    mode = 1; busy_len = 20;
    for (int i = 0; i < 20 && tx_q.size() == 0; i++) tick();
    check("mid_first_tx", tx_q.size(), 1);
    tick(); tick();
    check("mid_count_before", count, 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mode = 2;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_tx_start", tx_start, 0);
    tx_q.delete(); txc_q.delete();
    tick();
    check("mid_post_tx_start", tx_start, 0);
    for (int i = 0; i < 40; i++) tick();
    check("mid_no_tx", tx_q.size(), 0);
    check("mid_final_count", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
